// File: rtl/rv32i_sim_ctrl.sv
// Run controller for the RV32I SoPC bench: sequences the core reset, injects periodic
// interrupts, and decides pass/fail/timeout from tohost writes on the data bus.
module rv32i_sim_ctrl #(
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2500,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int unsigned NUM_IRQ        = 6,
    parameter int unsigned IRQ_PERIOD     = 0,
    parameter int unsigned CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_we_i,
    input  logic [31:0]        mem_addr_i,
    input  logic [31:0]        mem_wdata_i,
    output logic               core_rst_o,
    output logic [NUM_IRQ-1:0] int_o,
    output logic               done_o,
    output logic               pass_o,
    output logic               fail_o,
    output logic               timeout_o,
    output logic [31:0]        fail_code_o,
    output logic [CNT_W-1:0]   cycle_cnt_o
);

    localparam int unsigned IDX_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [31:0] HOLD_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] PER_LAST  = (IRQ_PERIOD > 0) ? 32'(IRQ_PERIOD - 1) : 32'd0;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IRQ - 1);

    typedef enum logic [1:0] {StHold, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [31:0]        hold_q, hold_d;
    logic [31:0]        irq_cnt_q, irq_cnt_d;
    logic [IDX_W-1:0]   irq_idx_q, irq_idx_d;
    logic               core_rst_q, core_rst_d;
    logic [NUM_IRQ-1:0] int_q, int_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               timeout_q, timeout_d;
    logic [31:0]        fail_code_q, fail_code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tohost_wr;

    assign tohost_wr = mem_we_i && (mem_addr_i == TOHOST_ADDR);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        irq_cnt_d   = irq_cnt_q;
        irq_idx_d   = irq_idx_q;
        core_rst_d  = core_rst_q;
        int_d       = '0;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        fail_code_d = fail_code_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StHold: begin
                hold_d = hold_q + 32'd1;
                if (hold_q == HOLD_LAST) begin
                    state_d    = StRun;
                    core_rst_d = 1'b0;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (tohost_wr) begin
                    // tohost beats timeout when both land on the same edge
                    state_d    = StDone;
                    core_rst_d = 1'b1;
                    irq_cnt_d  = '0;
                    done_d     = 1'b1;
                    if (mem_wdata_i == 32'd1) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d      = 1'b1;
                        fail_code_d = mem_wdata_i >> 1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d    = StDone;
                    core_rst_d = 1'b1;
                    irq_cnt_d  = '0;
                    done_d     = 1'b1;
                    timeout_d  = 1'b1;
                end else if (IRQ_PERIOD != 0) begin
                    if (irq_cnt_q == PER_LAST) begin
                        irq_cnt_d = '0;
                        int_d     = NUM_IRQ'(1) << irq_idx_q;
                        irq_idx_d = (irq_idx_q == IDX_LAST) ? '0 : irq_idx_q + 1'b1;
                    end else begin
                        irq_cnt_d = irq_cnt_q + 32'd1;
                    end
                end
            end
            StDone: begin
                core_rst_d = 1'b1;
            end
            default: begin
                state_d = StHold;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHold;
            hold_q      <= '0;
            irq_cnt_q   <= '0;
            irq_idx_q   <= '0;
            core_rst_q  <= 1'b1;
            int_q       <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_code_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            irq_cnt_q   <= irq_cnt_d;
            irq_idx_q   <= irq_idx_d;
            core_rst_q  <= core_rst_d;
            int_q       <= int_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            fail_code_q <= fail_code_d;
            cnt_q       <= cnt_d;
        end
    end

    assign core_rst_o  = core_rst_q;
    assign int_o       = int_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timeout_o   = timeout_q;
    assign fail_code_o = fail_code_q;
    assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_rv32i_sim_ctrl.sv
// Directed bench: u_a uses default parameters, u_b a short timeout with 3-line IRQ injection.
module tb_rv32i_sim_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    logic        core_rst_a, done_a, pass_a, fail_a, timeout_a;
    logic [5:0]  int_a;
    logic [31:0] fail_code_a, cnt_a;
    logic        core_rst_b, done_b, pass_b, fail_b, timeout_b;
    logic [2:0]  int_b;
    logic [31:0] fail_code_b, cnt_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rv32i_sim_ctrl u_a (
        .clk(clk), .rst(rst), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .core_rst_o(core_rst_a), .int_o(int_a), .done_o(done_a),
        .pass_o(pass_a), .fail_o(fail_a), .timeout_o(timeout_a), .fail_code_o(fail_code_a),
        .cycle_cnt_o(cnt_a)
    );

    rv32i_sim_ctrl #(
        .TIMEOUT_CYCLES(50), .NUM_IRQ(3), .IRQ_PERIOD(10)
    ) u_b (
        .clk(clk), .rst(rst), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .core_rst_o(core_rst_b), .int_o(int_b), .done_o(done_b),
        .pass_o(pass_b), .fail_o(fail_b), .timeout_o(timeout_b), .fail_code_o(fail_code_b),
        .cycle_cnt_o(cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst core_rst_a", {31'd0, core_rst_a}, 32'd1);
        chk("rst core_rst_b", {31'd0, core_rst_b}, 32'd1);
        chk("rst int_a", {26'd0, int_a}, 32'd0);
        chk("rst int_b", {29'd0, int_b}, 32'd0);
        chk("rst status_a", {28'd0, done_a, pass_a, fail_a, timeout_a}, 32'd0);
        chk("rst status_b", {28'd0, done_b, pass_b, fail_b, timeout_b}, 32'd0);
        chk("rst code_a", fail_code_a, 32'd0);
        chk("rst code_b", fail_code_b, 32'd0);
        chk("rst cnt_a", cnt_a, 32'd0);
        chk("rst cnt_b", cnt_b, 32'd0);
    endtask

    // Releases rst and checks core_rst stays high for exactly 4 edges.
    task automatic release_seq();
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("hold core_rst_a", {31'd0, core_rst_a}, 32'd1);
            chk("hold core_rst_b", {31'd0, core_rst_b}, 32'd1);
            chk("hold cnt_a", cnt_a, 32'd0);
        end
        tick();
        chk("run core_rst_a", {31'd0, core_rst_a}, 32'd0);
        chk("run core_rst_b", {31'd0, core_rst_b}, 32'd0);
        chk("run cnt_a0", cnt_a, 32'd0);
        chk("run cnt_b0", cnt_b, 32'd0);
    endtask

    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data);
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = data;
    endtask

    initial begin
        logic [2:0] exp_irq;
        rst = 1'b1;
        bus(1'b0, 32'h0, 32'h0);
        repeat (5) tick();
        check_reset();

        // Run until u_b times out, checking counting and IRQ rotation
        release_seq();
        for (int k = 1; k <= 49; k++) begin
            tick();
            chk("cnt_a run", cnt_a, k);
            chk("int_a idle", {26'd0, int_a}, 32'd0);
            case (k)
                10, 40:  exp_irq = 3'b001;
                20:      exp_irq = 3'b010;
                30:      exp_irq = 3'b100;
                default: exp_irq = 3'b000;
            endcase
            chk("int_b pulse", {29'd0, int_b}, {29'd0, exp_irq});
        end
        chk("timeout_b early", {31'd0, timeout_b}, 32'd0);
        tick();
        chk("to done_b", {31'd0, done_b}, 32'd1);
        chk("to timeout_b", {31'd0, timeout_b}, 32'd1);
        chk("to pass_fail_b", {30'd0, pass_b, fail_b}, 32'd0);
        chk("to cnt_b", cnt_b, 32'd50);
        chk("to core_rst_b", {31'd0, core_rst_b}, 32'd1);
        chk("to done_a", {31'd0, done_a}, 32'd0);

        // Non-tohost write has no effect
        repeat (10) tick();
        bus(1'b1, 32'h0000_1004, 32'd1);
        tick();
        bus(1'b0, 32'h0, 32'h0);
        chk("other addr cnt_a", cnt_a, 32'd61);
        chk("other addr status_a", {28'd0, done_a, pass_a, fail_a, timeout_a}, 32'd0);
        for (int k = 62; k <= 100; k++) begin
            tick();
            chk("int_b done", {29'd0, int_b}, 32'd0);
        end
        chk("cnt_a at 100", cnt_a, 32'd100);

        // Passing tohost write at cycle 100
        bus(1'b1, 32'h0000_1000, 32'd1);
        tick();
        bus(1'b0, 32'h0, 32'h0);
        chk("pass status_a", {28'd0, done_a, pass_a, fail_a, timeout_a}, 32'b1100);
        chk("pass cnt_a", cnt_a, 32'd101);
        chk("pass core_rst_a", {31'd0, core_rst_a}, 32'd1);
        chk("sticky status_b", {28'd0, done_b, pass_b, fail_b, timeout_b}, 32'b1001);
        repeat (3) tick();
        chk("frozen cnt_a", cnt_a, 32'd101);
        chk("frozen cnt_b", cnt_b, 32'd50);

        // Reset from DONE, then restart and reset mid-RUN at cycle 30
        rst = 1'b1;
        tick();
        check_reset();
        release_seq();
        repeat (30) tick();
        chk("restart cnt_a", cnt_a, 32'd30);
        chk("restart int_b", {29'd0, int_b}, 32'b100);
        rst = 1'b1;
        tick();
        check_reset();
        release_seq();
        repeat (10) tick();
        chk("irq idx reset", {29'd0, int_b}, 32'b001);

        // Failing tohost write at cycle 20
        repeat (10) tick();
        chk("fail pre cnt_a", cnt_a, 32'd20);
        bus(1'b1, 32'h0000_1000, 32'h0000_0007);
        tick();
        bus(1'b0, 32'h0, 32'h0);
        chk("fail status_a", {28'd0, done_a, pass_a, fail_a, timeout_a}, 32'b1010);
        chk("fail code_a", fail_code_a, 32'd3);
        chk("fail cnt_a", cnt_a, 32'd21);
        chk("fail status_b", {28'd0, done_b, pass_b, fail_b, timeout_b}, 32'b1010);
        chk("fail code_b", fail_code_b, 32'd3);
        chk("fail int_b", {29'd0, int_b}, 32'd0);

        // tohost write coinciding with u_b timeout: pass wins
        rst = 1'b1;
        tick();
        check_reset();
        release_seq();
        repeat (49) tick();
        chk("race pre cnt_b", cnt_b, 32'd49);
        bus(1'b1, 32'h0000_1000, 32'd1);
        tick();
        bus(1'b0, 32'h0, 32'h0);
        chk("race status_b", {28'd0, done_b, pass_b, fail_b, timeout_b}, 32'b1100);
        chk("race cnt_b", cnt_b, 32'd50);
        chk("race status_a", {28'd0, done_a, pass_a, fail_a, timeout_a}, 32'b1100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
